// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 8-bit UART transmitter between NUM_REQ requesters.
// Each granted byte is handed to the UART with txStart, acknowledged once the
// UART reports busy, and retired when the UART reports done.
// A START phase that never sees txBusy is abandoned after START_TIMEOUT cycles.
// Optional macro UART_TX_ARB_ROUND_ROBIN_EN switches to round-robin selection.
// Without it, selection is fixed priority and the lowest index wins.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no owner; picks a winner when en=1 and any req is high
// START     | txStart high, waiting for the UART to report txBusy
// WAIT_DONE | byte accepted, waiting for txDone; en=0 does not abort

module uart_tx_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int START_TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] reqData,
   output logic [NUM_REQ-1:0]   grant,
   output logic [NUM_REQ-1:0]   ack,
   output logic [NUM_REQ-1:0]   done,
   output logic                 startErr,
   output logic                 busy,
   output logic                 txEn,
   output logic                 txStart,
   output logic [7:0]           txIn,
   input  logic                 txBusy,
   input  logic                 txDone
);

   localparam int          IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [15:0] TMO_LAST = 16'(START_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_START     = 2'd1,
      S_WAIT_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic                 start_err_q, start_err_d;
   logic                 busy_q, busy_d;
   logic                 tx_en_q, tx_en_d;
   logic                 tx_start_q, tx_start_d;
   logic [7:0]           tx_in_q, tx_in_d;
   logic [15:0]          tmo_q, tmo_d;

   logic                 win_found;
   logic [NUM_REQ-1:0]   win_oh;
   logic [7:0]           win_data;

`ifdef UART_TX_ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [IDX_W-1:0]     win_q, win_d;
   logic [IDX_W-1:0]     win_idx, hi_idx, lo_idx;
   logic                 hi_found, lo_found;

   // Round-robin pick: lowest asserted index at or above the pointer, else wrap to the lowest overall.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req[i] && !lo_found) begin
            lo_found = 1'b1;
            lo_idx   = IDX_W'(i);
         end
         if (req[i] && !hi_found && (IDX_W'(i) >= ptr_q)) begin
            hi_found = 1'b1;
            hi_idx   = IDX_W'(i);
         end
      end
      win_found = lo_found;
      win_idx   = hi_found ? hi_idx : lo_idx;
      win_oh    = '0;
      win_data  = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IDX_W'(i) == win_idx) begin
            win_oh[i] = win_found;
            win_data  = reqData[8*i +: 8];
         end
      end
   end

   // Remember the winner's index; advance the pointer past it only when its byte completes.
   always_comb begin
      win_d = win_q;
      ptr_d = ptr_q;
      if (state_q == S_IDLE && en && win_found) begin
         win_d = win_idx;
      end
      if (state_q == S_WAIT_DONE && !txBusy && txDone) begin
         ptr_d = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
      end
   end

   // Pointer and winner index registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
         win_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         win_q <= win_d;
      end
   end
`else
   // Fixed priority pick: the lowest asserted index wins.
   always_comb begin
      win_found = 1'b0;
      win_oh    = '0;
      win_data  = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req[i] && !win_found) begin
            win_found = 1'b1;
            win_oh[i] = 1'b1;
            win_data  = reqData[8*i +: 8];
         end
      end
   end
`endif

   // Next-state and registered-output logic; pulses default low, the owner and byte hold.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      ack_d       = '0;
      done_d      = '0;
      start_err_d = 1'b0;
      tx_start_d  = tx_start_q;
      tx_in_d     = tx_in_q;
      tmo_d       = tmo_q;

      unique case (state_q)
         S_IDLE: begin
            tx_start_d = 1'b0;
            grant_d    = '0;
            if (en && win_found) begin
               state_d    = S_START;
               grant_d    = win_oh;
               tx_in_d    = win_data;
               tx_start_d = 1'b1;
               tmo_d      = 16'd0;
            end
         end
         S_START: begin
            tmo_d = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
            if (!en) begin
               state_d    = S_IDLE;
               grant_d    = '0;
               tx_start_d = 1'b0;
            end else if (txBusy) begin
               state_d    = S_WAIT_DONE;
               tx_start_d = 1'b0;
               ack_d      = grant_q;
            end else if (tmo_q >= TMO_LAST) begin
               state_d     = S_IDLE;
               grant_d     = '0;
               tx_start_d  = 1'b0;
               start_err_d = 1'b1;
            end
         end
         S_WAIT_DONE: begin
            tx_start_d = 1'b0;
            if (!txBusy && txDone) begin
               state_d = S_IDLE;
               grant_d = '0;
               done_d  = grant_q;
            end
         end
         default: begin
            state_d    = S_IDLE;
            grant_d    = '0;
            tx_start_d = 1'b0;
         end
      endcase

      busy_d  = (state_d != S_IDLE);
      tx_en_d = en | (state_d == S_WAIT_DONE);
   end

   // State and output registers; reset clears everything at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         ack_q       <= '0;
         done_q      <= '0;
         start_err_q <= 1'b0;
         busy_q      <= 1'b0;
         tx_en_q     <= 1'b0;
         tx_start_q  <= 1'b0;
         tx_in_q     <= 8'h00;
         tmo_q       <= 16'd0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         ack_q       <= ack_d;
         done_q      <= done_d;
         start_err_q <= start_err_d;
         busy_q      <= busy_d;
         tx_en_q     <= tx_en_d;
         tx_start_q  <= tx_start_d;
         tx_in_q     <= tx_in_d;
         tmo_q       <= tmo_d;
      end
   end

   assign grant    = grant_q;
   assign ack      = ack_q;
   assign done     = done_q;
   assign startErr = start_err_q;
   assign busy     = busy_q;
   assign txEn     = tx_en_q;
   assign txStart  = tx_start_q;
   assign txIn     = tx_in_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, START_TIMEOUT=10).
// The UART handshake is driven by hand from the scenario tasks.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic [3:0]  req = 4'b0000;
   logic [31:0] reqData = 32'h44332211;
   logic        txBusy = 1'b0;
   logic        txDone = 1'b0;
   logic [3:0]  grant, ack, done;
   logic        startErr, busy, txEn, txStart;
   logic [7:0]  txIn;

   int tests = 0;
   int fails = 0;

   uart_tx_arbiter #(.NUM_REQ(4), .START_TIMEOUT(10)) dut (
      .clk(clk), .reset(reset), .en(en), .req(req), .reqData(reqData),
      .grant(grant), .ack(ack), .done(done), .startErr(startErr),
      .busy(busy), .txEn(txEn), .txStart(txStart), .txIn(txIn),
      .txBusy(txBusy), .txDone(txDone)
   );

   always #5 clk = ~clk;

   // Runs one transfer: waits for txStart, then emulates UART busy and done.
   task automatic serve(output logic [3:0] g, output logic [7:0] d,
                        output logic [3:0] a, output logic [3:0] dn, output bit ok);
      ok = 1'b0; g = '0; d = '0; a = '0; dn = '0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         if (txStart) ok = 1'b1;
      end
      if (ok) begin
         g = grant; d = txIn;
         txBusy = 1'b1;
         @(negedge clk);
         a = ack;
         txBusy = 1'b0; txDone = 1'b1;
         @(negedge clk);
         dn = done;
         txDone = 1'b0;
      end
   endtask

   task automatic test_reset();
      @(negedge clk); @(negedge clk);
      tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL reset_grant got %b exp 0000", grant); end
      tests++; if ({ack, done} !== 8'h00) begin fails++; $display("FAIL reset_ack_done got %b exp 00000000", {ack, done}); end
      tests++; if ({busy, txStart, txEn, startErr} !== 4'b0000) begin fails++; $display("FAIL reset_ctrl got %b exp 0000", {busy, txStart, txEn, startErr}); end
      tests++; if (txIn !== 8'h00) begin fails++; $display("FAIL reset_txIn got %h exp 00", txIn); end
      reset = 1'b0;
      @(negedge clk);
      tests++; if (busy !== 1'b0 || grant !== 4'b0000) begin fails++; $display("FAIL post_reset_idle busy %b grant %b exp 0 0000", busy, grant); end
   endtask

   task automatic test_priority();
      logic [3:0] exp_g [5];
      logic [7:0] exp_d [5];
      logic [3:0] g, a, dn;
      logic [7:0] d;
      bit ok;
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
`else
      exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
      exp_d = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
`endif
      reqData = 32'h44332211;
      en = 1'b1; req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         serve(g, d, a, dn, ok);
         tests++; if (!ok) begin fails++; $display("FAIL prio_start_timeout xfer %0d no txStart", k); end
         tests++; if (g !== exp_g[k]) begin fails++; $display("FAIL prio_grant xfer %0d got %b exp %b", k, g, exp_g[k]); end
         tests++; if (d !== exp_d[k]) begin fails++; $display("FAIL prio_txIn xfer %0d got %h exp %h", k, d, exp_d[k]); end
         tests++; if (a !== exp_g[k]) begin fails++; $display("FAIL prio_ack xfer %0d got %b exp %b", k, a, exp_g[k]); end
         tests++; if (dn !== exp_g[k]) begin fails++; $display("FAIL prio_done xfer %0d got %b exp %b", k, dn, exp_g[k]); end
         tests++; if (busy !== 1'b0 || grant !== 4'b0000) begin fails++; $display("FAIL prio_idle_gap xfer %0d busy %b grant %b exp 0 0000", k, busy, grant); end
      end
      req = 4'b0000;
      @(negedge clk);
   endtask

   task automatic test_single();
      en = 1'b1;
      reqData = 32'h77A56655;
      req = 4'b0100;
      @(negedge clk);
      tests++; if (grant !== 4'b0100) begin fails++; $display("FAIL single_grant got %b exp 0100", grant); end
      tests++; if (txIn !== 8'hA5) begin fails++; $display("FAIL single_txIn got %h exp a5", txIn); end
      tests++; if (txStart !== 1'b1 || busy !== 1'b1 || txEn !== 1'b1) begin fails++; $display("FAIL single_start txStart %b busy %b txEn %b exp 1 1 1", txStart, busy, txEn); end
      reqData = 32'h77006655;
      txBusy = 1'b1;
      @(negedge clk);
      tests++; if (ack !== 4'b0100 || txStart !== 1'b0) begin fails++; $display("FAIL single_ack ack %b txStart %b exp 0100 0", ack, txStart); end
      req = 4'b0000;
      @(negedge clk);
      tests++; if (ack !== 4'b0000 || grant !== 4'b0100 || busy !== 1'b1) begin fails++; $display("FAIL single_wait ack %b grant %b busy %b exp 0000 0100 1", ack, grant, busy); end
      tests++; if (txIn !== 8'hA5) begin fails++; $display("FAIL single_txIn_hold got %h exp a5", txIn); end
      @(negedge clk);
      txBusy = 1'b0; txDone = 1'b1;
      @(negedge clk);
      txDone = 1'b0;
      tests++; if (done !== 4'b0100 || grant !== 4'b0000) begin fails++; $display("FAIL single_done done %b grant %b exp 0100 0000", done, grant); end
      @(negedge clk);
      tests++; if (done !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL single_done_pulse done %b busy %b exp 0000 0", done, busy); end
   endtask

   task automatic test_timeout();
      en = 1'b1; txBusy = 1'b0;
      req = 4'b0010;
      @(negedge clk);
      tests++; if (grant !== 4'b0010 || txStart !== 1'b1) begin fails++; $display("FAIL tmo_enter grant %b txStart %b exp 0010 1", grant, txStart); end
      req = 4'b0000;
      for (int n = 1; n <= 11; n++) begin
         @(negedge clk);
         tests++; if (ack !== 4'b0000) begin fails++; $display("FAIL tmo_no_ack cycle %0d got %b exp 0000", n, ack); end
         if (n < 10) begin
            tests++; if (startErr !== 1'b0 || txStart !== 1'b1) begin fails++; $display("FAIL tmo_early cycle %0d startErr %b txStart %b exp 0 1", n, startErr, txStart); end
         end else if (n == 10) begin
            tests++; if (startErr !== 1'b1) begin fails++; $display("FAIL tmo_err cycle %0d got %b exp 1", n, startErr); end
            tests++; if (txStart !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL tmo_abort txStart %b grant %b busy %b exp 0 0000 0", txStart, grant, busy); end
         end else begin
            tests++; if (startErr !== 1'b0) begin fails++; $display("FAIL tmo_pulse cycle %0d got %b exp 0", n, startErr); end
         end
      end
   endtask

   task automatic test_en();
      en = 1'b0; req = 4'b0001;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         tests++; if (grant !== 4'b0000 || busy !== 1'b0 || txEn !== 1'b0) begin fails++; $display("FAIL en_block grant %b busy %b txEn %b exp 0000 0 0", grant, busy, txEn); end
      end
      en = 1'b1;
      @(negedge clk);
      tests++; if (grant !== 4'b0001 || txEn !== 1'b1) begin fails++; $display("FAIL en_grant grant %b txEn %b exp 0001 1", grant, txEn); end
      txBusy = 1'b1;
      @(negedge clk);
      tests++; if (ack !== 4'b0001) begin fails++; $display("FAIL en_ack got %b exp 0001", ack); end
      en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tests++; if (busy !== 1'b1 || grant !== 4'b0001 || txEn !== 1'b1) begin fails++; $display("FAIL en_wait_hold busy %b grant %b txEn %b exp 1 0001 1", busy, grant, txEn); end
      txBusy = 1'b0; txDone = 1'b1;
      @(negedge clk);
      txDone = 1'b0;
      tests++; if (done !== 4'b0001) begin fails++; $display("FAIL en_done got %b exp 0001", done); end
      @(negedge clk);
      tests++; if (grant !== 4'b0000 || busy !== 1'b0 || txEn !== 1'b0) begin fails++; $display("FAIL en_after grant %b busy %b txEn %b exp 0000 0 0", grant, busy, txEn); end
      req = 4'b0000;
   endtask

   task automatic test_en_abort();
      en = 1'b1; req = 4'b0100;
      @(negedge clk);
      tests++; if (grant !== 4'b0100) begin fails++; $display("FAIL abort_grant got %b exp 0100", grant); end
      en = 1'b0; req = 4'b0000;
      @(negedge clk);
      tests++; if ({grant, ack} !== 8'h00 || txStart !== 1'b0 || busy !== 1'b0 || startErr !== 1'b0) begin fails++; $display("FAIL abort_state grant %b ack %b txStart %b busy %b startErr %b exp all 0", grant, ack, txStart, busy, startErr); end
   endtask

   task automatic test_reset_mid();
      en = 1'b1; req = 4'b0010;
      @(negedge clk);
      txBusy = 1'b1;
      @(negedge clk);
      tests++; if (ack !== 4'b0010) begin fails++; $display("FAIL rmid_ack got %b exp 0010", ack); end
      req = 4'b0000;
      @(negedge clk);
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rmid_wait busy %b exp 1", busy); end
      reset = 1'b1;
      #1;
      tests++; if ({grant, ack, done} !== 12'h000) begin fails++; $display("FAIL rmid_vectors grant %b ack %b done %b exp 0", grant, ack, done); end
      tests++; if ({busy, txStart, txEn, startErr} !== 4'b0000 || txIn !== 8'h00) begin fails++; $display("FAIL rmid_ctrl ctrl %b txIn %h exp 0000 00", {busy, txStart, txEn, startErr}, txIn); end
      @(negedge clk);
      reset = 1'b0; txBusy = 1'b0;
      req = 4'b1001;
      @(negedge clk);
      tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL rmid_ptr grant %b exp 0001", grant); end
      en = 1'b0; req = 4'b0000;
      @(negedge clk);
      en = 1'b1; req = 4'b1000;
      @(negedge clk);
      tests++; if (grant !== 4'b1000 || txIn !== 8'h77) begin fails++; $display("FAIL rmid_req3 grant %b txIn %h exp 1000 77", grant, txIn); end
      en = 1'b0; req = 4'b0000;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_priority();
      test_single();
      test_timeout();
      test_en();
      test_en_abort();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one Uart8 transmitter; legal range 2..8.
REQ-002 Parameter START_TIMEOUT, default 255: maximum clk cycles in START before abort; legal range 1..65535.
REQ-003 Port clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port en  input  1  arbiter enable; low blocks new grants.
REQ-006 Port req  input  NUM_REQ  per-requester byte-valid, level, held until ack.
REQ-007 Port reqData  input  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
REQ-008 Port grant  output  NUM_REQ  one-hot current owner; all zero when idle.
REQ-009 Port ack  output  NUM_REQ  one-cycle pulse: byte of requester i accepted by the UART.
REQ-010 Port done  output  NUM_REQ  one-cycle pulse: byte of requester i fully transmitted.
REQ-011 Port startErr  output  1  one-cycle pulse: START timed out.
REQ-012 Port busy  output  1  high whenever state is not IDLE.
REQ-013 Port txEn  output  1  drives Uart8 txEn.
REQ-014 Port txStart  output  1  drives Uart8 txStart.
REQ-015 Port txIn  output  8  drives Uart8 txIn.
REQ-016 Port txBusy  input  1  from Uart8 txBusy.
REQ-017 Port txDone  input  1  from Uart8 txDone.

Function
REQ-018 FSM states SHALL be IDLE, START, WAIT_DONE; all outputs registered.
REQ-019 IDLE: if en=1 and any req=1, select winner, go to START next cycle; grant, txIn=reqData[winner], txStart=1 all visible one cycle after the req sample.
REQ-020 txIn SHALL be latched at grant and held stable through START and WAIT_DONE, independent of later reqData changes.
REQ-021 START: txStart=1 until txBusy=1 is sampled; then txStart=0, ack[winner] pulses one cycle, go to WAIT_DONE.
REQ-022 START: if en=0, or START_TIMEOUT cycles pass without txBusy, then txStart=0, grant cleared, go to IDLE, no ack; startErr pulses only on timeout.
REQ-023 WAIT_DONE: on txBusy=0 and txDone=1, done[winner] pulses one cycle, grant cleared, go to IDLE; en=0 here SHALL NOT abort.
REQ-024 Minimum one IDLE cycle between consecutive grants; a req still high after its done is treated as a new request.
REQ-025 txEn SHALL equal en OR (state==WAIT_DONE), registered.
REQ-026 Timeout counter 16 bits, cleared on START entry, saturating; no wrap.
REQ-027 req deasserted by its owner during START/WAIT_DONE SHALL be ignored until return to IDLE.
REQ-028 At most one bit of grant, ack, done set in any cycle.

Reset
REQ-029 reset=1 SHALL immediately force IDLE, grant=0, ack=0, done=0, startErr=0, busy=0, txStart=0, txEn=0, txIn=8'h00, timeout counter 0, round-robin pointer 0.
REQ-030 Reset mid-transfer SHALL drop txStart and grant without ack or done pulses.

Configuration
REQ-031 Macro UART_TX_ARB_ROUND_ROBIN_EN defined: winner is first asserted req searching upward from (last winner+1) mod NUM_REQ; pointer updates only on done.
REQ-032 Macro undefined: fixed priority, lowest asserted index wins; no pointer register.

Verification
REQ-033 Single req[2]=1, reqData[2]=8'hA5, Uart8 attached -> grant=4'b0100 next cycle, txIn=8'hA5, ack[2] after txBusy, done[2] after txDone, receiving Uart8 rxOut=8'hA5.
REQ-034 req=4'b1111 held, distinct bytes -> with macro: done order 0,1,2,3,0; without: requester 0 served repeatedly.
REQ-035 txBusy tied 0, START_TIMEOUT=10, req[1]=1 -> startErr pulse exactly 10 cycles after START entry, txStart=0, state IDLE, no ack.
REQ-036 en=0 with req=4'b0001 -> grant stays 0; en=1 -> grant=4'b0001 next cycle; en=0 during WAIT_DONE -> byte completes, done[0] pulses.
REQ-037 reset asserted during WAIT_DONE -> all outputs 0 same cycle; after release, req[3]=1 -> grant[3] (with macro, pointer reset to 0).
